spi_burst_sequencer: RTL and testbench

Parametrised multi-byte SPI transaction sequencer between system logic and the `SPI_Master_With_Single_CS` byte interface. Accepts a register read/write command (address, length, write payload), emits one header byte plus N payload bytes under a single CS assertion, and returns the MISO bytes as one parallel response word. An optional auto-repeat mode re-issues the last command every `POLL_PERIOD` cycles, which supports periodic accelerometer burst reads (e.g. 6-byte XYZ from 0x32).

---
 rtl/spi_seq_pkg.sv | 30 +++
 rtl/spi_seq_period_timer.sv | 30 +++
 rtl/spi_burst_sequencer.sv | 148 ++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types and constants for the SPI burst sequencer
package spi_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT_RX,
    S_DATA,
    S_DONE,
    S_GAP
  } seq_state_t;

  localparam int HDR_RW_BIT = 7;
  localparam int HDR_MB_BIT = 6;

  localparam logic [5:0] REG_DEVID     = 6'h00;
  localparam logic [5:0] REG_POWER_CTL = 6'h2D;
  localparam logic [5:0] REG_DATAX0    = 6'h32;

  // Header byte: read/write flag, multi-byte flag, 6-bit register address
  function automatic logic [7:0] make_header(input logic rw, input logic mb,
                                             input logic [5:0] addr);
    logic [7:0] h;
    h = {2'b00, addr};
    h[HDR_RW_BIT] = rw;
    h[HDR_MB_BIT] = mb;
    return h;
  endfunction

endpackage

// File: rtl/spi_seq_period_timer.sv
// rtl/spi_seq_period_timer.sv - load/enable down-counter pacing auto-repeat
module spi_seq_period_timer #(
  parameter int PERIOD = 100000
) (
  input  logic CLK100MHZ,
  input  logic RESET_N,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(PERIOD + 1);

  logic [W-1:0] count;

  // Load with PERIOD-1, count down while enabled, hold at zero
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (load) begin
      count <= W'(PERIOD - 1);
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Expire one count early so the header state lines up with the count reaching zero
  assign expire = (count <= W'(1));

endmodule

// File: rtl/spi_burst_sequencer.sv
// rtl/spi_burst_sequencer.sv - multi-byte SPI register transaction sequencer
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int MAX_BYTES   = 7,
  parameter int CNT_W       = $clog2(MAX_BYTES + 1),
  parameter int POLL_PERIOD = 100000
) (
  input  logic                       CLK100MHZ,
  input  logic                       RESET_N,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_rw,
  input  logic [5:0]                 cmd_addr,
  input  logic [CNT_W-1:0]           cmd_len,
  input  logic [8*(MAX_BYTES-1)-1:0] cmd_wdata,
  input  logic                       auto_en,
  output logic                       rsp_valid,
  output logic [8*(MAX_BYTES-1)-1:0] rsp_data,
  output logic [CNT_W-1:0]           rsp_len,
  output logic                       err_len,
  output logic [CNT_W-1:0]           m_tx_count,
  output logic [7:0]                 m_tx_byte,
  output logic                       m_tx_dv,
  input  logic                       m_tx_ready,
  input  logic [7:0]                 m_rx_byte,
  input  logic                       m_rx_dv
);

  localparam int LANES = MAX_BYTES - 1;
  localparam int DW    = 8 * LANES;

  seq_state_t       state, state_d;
  logic             cmd_rw_q;
  logic [5:0]       cmd_addr_q;
  logic [CNT_W-1:0] cmd_len_q;
  logic [DW-1:0]    cmd_wdata_q;
  logic [CNT_W-1:0] byte_idx;
  logic [DW-1:0]    shadow, shadow_upd;
  logic [7:0]       tx_byte_d;
  logic             legal, accept, start_new, start_repeat;
  logic             tx_fire, rx_take, rx_last, gap_expire;
  int               lane;

  assign legal  = (cmd_len != '0) && (cmd_len <= CNT_W'(LANES));
  assign accept = cmd_valid && cmd_ready;

  spi_seq_period_timer #(.PERIOD(POLL_PERIOD)) u_timer (
    .CLK100MHZ (CLK100MHZ),
    .RESET_N   (RESET_N),
    .load      (rx_last),
    .en        ((state == S_DONE) || (state == S_GAP)),
    .expire    (gap_expire)
  );

  // State register
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (start_new) state_d = S_HDR;
      S_GAP: begin
        if (start_new)       state_d = S_HDR;
        else if (!auto_en)   state_d = S_IDLE;
        else if (gap_expire) state_d = S_HDR;
      end
      S_HDR,
      S_DATA:    if (m_tx_ready) state_d = S_WAIT_RX;
      S_WAIT_RX: if (rx_take) state_d = rx_last ? S_DONE : S_DATA;
      S_DONE:    state_d = auto_en ? S_GAP : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: transaction events, next MOSI byte and merged MISO shadow
  always_comb begin
    start_new    = accept && legal;
    start_repeat = (state == S_GAP) && !start_new && auto_en && gap_expire;
    tx_fire      = ((state == S_HDR) || (state == S_DATA)) && m_tx_ready;
    rx_take      = (state == S_WAIT_RX) && m_rx_dv;
    rx_last      = rx_take && (byte_idx == cmd_len_q);
    lane         = int'(byte_idx) - 1;
    tx_byte_d    = make_header(cmd_rw_q, cmd_len_q > CNT_W'(1), cmd_addr_q);
    if (state == S_DATA) begin
      tx_byte_d = cmd_rw_q ? 8'h00 : cmd_wdata_q[8*lane +: 8];
    end
    shadow_upd = shadow;
    if (rx_take && (byte_idx != '0)) begin
      shadow_upd[8*lane +: 8] = m_rx_byte;
    end
  end

  // Datapath: command latch, master handshake, response capture
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd_ready   <= 1'b1;
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_wdata_q <= '0;
      byte_idx    <= '0;
      shadow      <= '0;
      m_tx_dv     <= 1'b0;
      m_tx_byte   <= '0;
      m_tx_count  <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_len     <= '0;
      err_len     <= 1'b0;
    end else begin
      cmd_ready <= (state_d == S_IDLE) || (state_d == S_GAP);
      err_len   <= accept && !legal;
      m_tx_dv   <= 1'b0;
      rsp_valid <= 1'b0;
      if (start_new) begin
        cmd_rw_q    <= cmd_rw;
        cmd_addr_q  <= cmd_addr;
        cmd_len_q   <= cmd_len;
        cmd_wdata_q <= cmd_wdata;
      end
      if (start_new || start_repeat) begin
        byte_idx <= '0;
        shadow   <= '0;
      end
      if (tx_fire) begin
        m_tx_dv   <= 1'b1;
        m_tx_byte <= tx_byte_d;
        if (state == S_HDR) m_tx_count <= cmd_len_q + CNT_W'(1);
      end
      if (rx_take) begin
        shadow <= shadow_upd;
        if (rx_last) begin
          rsp_data  <= shadow_upd;
          rsp_len   <= cmd_len_q;
          rsp_valid <= 1'b1;
        end else begin
          byte_idx <= byte_idx + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// tb/tb_spi_burst_sequencer.sv - directed table-driven bench for spi_burst_sequencer
module tb_spi_burst_sequencer;
  import spi_seq_pkg::*;

  localparam int MAX_BYTES = 7;
  localparam int CNT_W     = 3;
  localparam int POLL      = 20;

  logic        CLK100MHZ = 1'b0;
  logic        RESET_N   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw    = 1'b0;
  logic [5:0]  cmd_addr  = '0;
  logic [2:0]  cmd_len   = '0;
  logic [47:0] cmd_wdata = '0;
  logic        auto_en   = 1'b0;
  logic        rsp_valid;
  logic [47:0] rsp_data;
  logic [2:0]  rsp_len;
  logic        err_len;
  logic [2:0]  m_tx_count;
  logic [7:0]  m_tx_byte;
  logic        m_tx_dv;
  logic        m_tx_ready = 1'b1;
  logic [7:0]  m_rx_byte  = '0;
  logic        m_rx_dv    = 1'b0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  spi_burst_sequencer #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W), .POLL_PERIOD(POLL)) dut (
    .CLK100MHZ(CLK100MHZ), .RESET_N(RESET_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .auto_en(auto_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_len(rsp_len), .err_len(err_len),
    .m_tx_count(m_tx_count), .m_tx_byte(m_tx_byte), .m_tx_dv(m_tx_dv),
    .m_tx_ready(m_tx_ready), .m_rx_byte(m_rx_byte), .m_rx_dv(m_rx_dv)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  int rsp_cnt = 0, last_rsp_cyc = -1, err_cnt = 0, last_err_cyc = -1;
  int dv_cnt = 0, dv_double = 0, last_rx_cyc = -1, pend = 0;
  logic prev_dv = 1'b0;
  logic [47:0] cap_data;
  logic [2:0]  cap_len, cap_count;
  int dv_cycs[$];
  logic [7:0] mosi_q[$];
  logic [7:0] miso_q[$];

  // Monitor plus SPI slave model: answers each MOSI byte with the next MISO byte 3 cycles later
  always @(negedge CLK100MHZ) begin
    if (rsp_valid) begin
      rsp_cnt++; last_rsp_cyc = cyc;
      cap_data = rsp_data; cap_len = rsp_len; cap_count = m_tx_count;
    end
    if (err_len) begin err_cnt++; last_err_cyc = cyc; end
    if (m_tx_dv) begin
      dv_cnt++; dv_cycs.push_back(cyc);
      if (prev_dv) dv_double++;
    end
    prev_dv = m_tx_dv;
    m_rx_dv = 1'b0;
    if (!RESET_N) begin
      pend = 0;
    end else if (m_tx_dv) begin
      mosi_q.push_back(m_tx_byte);
      pend = 3;
    end else if (pend != 0) begin
      pend--;
      if (pend == 0) begin
        if (miso_q.size() != 0) m_rx_byte = miso_q.pop_front();
        else m_rx_byte = 8'h00;
        m_rx_dv = 1'b1;
        last_rx_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int first_dv_after(input int c);
    foreach (dv_cycs[i]) if (dv_cycs[i] > c) return dv_cycs[i];
    return -1;
  endfunction

  task automatic send_cmd(input logic rw, input logic [5:0] addr, input logic [2:0] len,
                          input logic [47:0] wd, output int acc_cyc);
    @(negedge CLK100MHZ);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_len = len; cmd_wdata = wd;
    @(negedge CLK100MHZ);
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int prev, input int budget, input string name);
    int n = 0;
    while (rsp_cnt == prev && n < budget) begin
      @(negedge CLK100MHZ);
      n++;
    end
    checks++;
    if (rsp_cnt == prev) begin
      failures++;
      $display("FAIL %s: no rsp_valid within %0d cycles (got 0 pulses, required 1)", name, budget);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [5:0]  addr;
    logic [2:0]  len;
    logic [47:0] wdata;
    logic [47:0] miso;
    logic [7:0]  exp_hdr;
    logic [47:0] exp_mosi;
    logic [2:0]  exp_count;
    logic [47:0] exp_rsp;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input string tag);
    int acc, prev;
    logic [47:0] got;
    miso_q.delete(); mosi_q.delete();
    miso_q.push_back(8'hA5);
    for (int i = 0; i < int'(v.len); i++) miso_q.push_back(v.miso[8*i +: 8]);
    prev = rsp_cnt;
    send_cmd(v.rw, v.addr, v.len, v.wdata, acc);
    wait_rsp(prev, 200, {tag, "_done"});
    repeat (3) @(negedge CLK100MHZ);
    got = '0;
    for (int i = 1; i < mosi_q.size() && i <= 6; i++) got[8*(i-1) +: 8] = mosi_q[i];
    chk({tag, "_mosi_cnt"}, mosi_q.size(), int'(v.len) + 1);
    chk({tag, "_hdr"}, (mosi_q.size() != 0) ? mosi_q[0] : 8'hXX, v.exp_hdr);
    chk({tag, "_payload"}, got, v.exp_mosi);
    chk({tag, "_hdr_lat"}, first_dv_after(acc), acc + 1);
    chk({tag, "_tx_count"}, cap_count, v.exp_count);
    chk({tag, "_rsp_data"}, cap_data, v.exp_rsp);
    chk({tag, "_rsp_len"}, cap_len, v.len);
    chk({tag, "_rsp_pulses"}, rsp_cnt, prev + 1);
    chk({tag, "_rsp_lat"}, last_rsp_cyc, last_rx_cyc + 1);
    chk({tag, "_rsp_hold"}, rsp_data, v.exp_rsp);
  endtask

  initial begin
    int acc, prev, pe, pd, r1, r2, n;

    vecs[0] = '{rw:1'b1, addr:REG_DEVID, len:3'd1, wdata:48'h0, miso:48'h0000000000E5,
                exp_hdr:8'h80, exp_mosi:48'h0, exp_count:3'd2, exp_rsp:48'h0000000000E5};
    vecs[1] = '{rw:1'b0, addr:REG_POWER_CTL, len:3'd1, wdata:48'h08, miso:48'h00000000005A,
                exp_hdr:8'h2D, exp_mosi:48'h08, exp_count:3'd2, exp_rsp:48'h00000000005A};
    vecs[2] = '{rw:1'b1, addr:REG_DATAX0, len:3'd6, wdata:48'h0, miso:48'h060504030201,
                exp_hdr:8'hF2, exp_mosi:48'h0, exp_count:3'd7, exp_rsp:48'h060504030201};
    vecs[3] = '{rw:1'b0, addr:6'h1E, len:3'd3, wdata:48'hFFFFFF332211, miso:48'h777777CCBBAA,
                exp_hdr:8'h5E, exp_mosi:48'h332211, exp_count:3'd4, exp_rsp:48'h000000CCBBAA};

    repeat (3) @(negedge CLK100MHZ);
    chk("reset_ctl", {cmd_ready, m_tx_dv, m_tx_byte, m_tx_count, rsp_valid, rsp_len, err_len},
        {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0});
    chk("reset_rsp_data", rsp_data, 48'h0);
    RESET_N = 1'b1;
    @(negedge CLK100MHZ);
    chk("idle_after_reset", {cmd_ready, m_tx_dv, rsp_valid}, 3'b100);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int k = 0; k < 2; k++) begin
      pe = err_cnt; pd = dv_cnt;
      send_cmd(1'b1, REG_DATAX0, (k == 0) ? 3'd0 : 3'd7, 48'h0, acc);
      repeat (5) @(negedge CLK100MHZ);
      chk($sformatf("err%0d_pulse", k), err_cnt, pe + 1);
      chk($sformatf("err%0d_lat", k), last_err_cyc, acc);
      chk($sformatf("err%0d_no_dv", k), dv_cnt, pd);
      chk($sformatf("err%0d_idle", k), {cmd_ready, dut.state}, {1'b1, S_IDLE});
    end

    auto_en = 1'b1;
    miso_q.delete(); dv_cycs.delete();
    prev = rsp_cnt;
    send_cmd(1'b1, REG_DATAX0, 3'd6, 48'h0, acc);
    wait_rsp(prev, 200, "auto_first");
    r1 = last_rsp_cyc;
    wait_rsp(prev + 1, 200, "auto_second");
    r2 = last_rsp_cyc;
    chk("auto_gap", first_dv_after(r1), r1 + POLL);
    repeat (8) @(negedge CLK100MHZ);
    chk("auto_in_gap", dut.state, S_GAP);
    auto_en = 1'b0;
    pd = dv_cnt;
    repeat (40) @(negedge CLK100MHZ);
    chk("auto_stop_no_dv", dv_cnt, pd);
    chk("auto_stop_idle", {cmd_ready, dut.state}, {1'b1, S_IDLE});
    chk("auto_no_repeat", first_dv_after(r2), -1);

    miso_q.delete(); mosi_q.delete();
    for (int i = 0; i < 7; i++) miso_q.push_back(8'h10 + 8'(i));
    send_cmd(1'b1, REG_DATAX0, 3'd6, 48'h0, acc);
    n = 0;
    while (mosi_q.size() < 3 && n < 100) begin
      @(negedge CLK100MHZ);
      n++;
    end
    chk("mid_reached_3rd_byte", mosi_q.size() >= 3, 1'b1);
    @(posedge CLK100MHZ);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_ctl", {cmd_ready, m_tx_dv, m_tx_byte, m_tx_count, rsp_valid, rsp_len, err_len},
        {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0});
    chk("midrst_rsp_data", rsp_data, 48'h0);
    chk("midrst_state", dut.state, S_IDLE);
    repeat (3) @(negedge CLK100MHZ);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK100MHZ);
    run_vec(vecs[0], "post_reset");

    chk("dv_single_cycle", dv_double, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
